// File: rtl/seg_display_scanner_if.sv
// seg_display_scanner_if
//   Bundles the signals between the syscall controller and the seven-segment
//   display scanner.
//   master : controller side, drives value/valueValid/blankLeading/halted and
//            observes the display drive and the frame pulse.
//   slave  : scanner side.
//   Signals:
//     value[31:0]   value to display
//     valueValid    single-cycle capture strobe for value
//     blankLeading  1 = blank leading zero digits
//     halted        1 = CPU halted, lights dp of digit 0
//     anode[7:0]    digit select, active-low
//     segment[7:0]  segment drive, active-low, bit0..6 = a..g, bit7 = dp
//     frameDone     one-cycle pulse at each frame wrap
interface seg_display_scanner_if;
   logic [31:0] value;
   logic        valueValid;
   logic        blankLeading;
   logic        halted;
   logic [7:0]  anode;
   logic [7:0]  segment;
   logic        frameDone;

   modport master (
      output value, valueValid, blankLeading, halted,
      input  anode, segment, frameDone
   );

   modport slave (
      input  value, valueValid, blankLeading, halted,
      output anode, segment, frameDone
   );
endinterface

// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Scans an 8-digit common-anode seven-segment display in hexadecimal.
//   A captured value is held back until the end of the current scan frame so
//   a single frame never mixes two values. Supports leading-zero blanking and
//   shows the CPU halt state on the decimal point of digit 0.
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous active-low reset
//     bus    seg_display_scanner_if.slave (value in, display drive out)
//   Parameter:
//     SCAN_DIV  clock cycles per digit slot, 2 .. 2**20
module seg_display_scanner #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic                 clock,
   input  logic                 reset,
   seg_display_scanner_if.slave bus
);

   localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] prescale_reg, prescale_next;
   logic [2:0]       digit_reg, digit_next;
   logic [31:0]      shown_reg, shown_next;
   logic [31:0]      pending_reg, pending_next;
   logic             pending_flag_reg, pending_flag_next;
   logic [7:0]       anode_reg, anode_next;
   logic [7:0]       segment_reg, segment_next;
   logic             frame_done_reg, frame_done_next;

   logic             tick;
   logic             boundary;
   logic [7:0]       lead_zero;
   logic [3:0]       nibble;
   logic [6:0]       pattern;
   logic             blank;

   assign tick     = (prescale_reg == CNT_LAST);
   assign boundary = tick && (digit_reg == 3'd7);

   // lead_zero[i]: every nibble from digit i upward is zero. Digit 0 is never
   // considered blankable so a zero value still shows a single "0".
   assign lead_zero[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_lead_zero
         assign lead_zero[gi] = ~|shown_reg[31:4*gi];
      end
   endgenerate

   // Scan timing and the frame-synchronous value hand-over.
   always_comb begin
      prescale_next     = tick ? '0 : prescale_reg + CNT_W'(1);
      digit_next        = tick ? digit_reg + 3'd1 : digit_reg;
      shown_next        = shown_reg;
      pending_next      = pending_reg;
      pending_flag_next = pending_flag_reg;
      frame_done_next   = boundary;
      if (boundary) begin
         // A strobe on the boundary cycle is newer than anything pending.
         if (bus.valueValid) begin
            shown_next        = bus.value;
            pending_flag_next = 1'b0;
         end else if (pending_flag_reg) begin
            shown_next        = pending_reg;
            pending_flag_next = 1'b0;
         end
      end else if (bus.valueValid) begin
         pending_next      = bus.value;
         pending_flag_next = 1'b1;
      end
   end

   assign nibble = shown_reg[{digit_reg, 2'b00} +: 4];
   assign blank  = bus.blankLeading && lead_zero[digit_reg];

   // Active-low a..g patterns; the dp bit is appended separately.
   always_comb begin
      pattern = 7'h7F;
      case (nibble)
         4'h0: pattern = 7'h40;
         4'h1: pattern = 7'h79;
         4'h2: pattern = 7'h24;
         4'h3: pattern = 7'h30;
         4'h4: pattern = 7'h19;
         4'h5: pattern = 7'h12;
         4'h6: pattern = 7'h02;
         4'h7: pattern = 7'h78;
         4'h8: pattern = 7'h00;
         4'h9: pattern = 7'h10;
         4'hA: pattern = 7'h08;
         4'hB: pattern = 7'h03;
         4'hC: pattern = 7'h46;
         4'hD: pattern = 7'h21;
         4'hE: pattern = 7'h06;
         4'hF: pattern = 7'h0E;
         default: pattern = 7'h7F;
      endcase
   end

   // Output drive reflects the current digit/shown state one clock later.
   always_comb begin
      anode_next   = ~(8'b1 << digit_reg);
      segment_next = {~((digit_reg == 3'd0) && bus.halted),
                      blank ? 7'h7F : pattern};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prescale_reg     <= '0;
         digit_reg        <= 3'd0;
         shown_reg        <= 32'd0;
         pending_reg      <= 32'd0;
         pending_flag_reg <= 1'b0;
         anode_reg        <= 8'hFF;
         segment_reg      <= 8'hFF;
         frame_done_reg   <= 1'b0;
      end else begin
         prescale_reg     <= prescale_next;
         digit_reg        <= digit_next;
         shown_reg        <= shown_next;
         pending_reg      <= pending_next;
         pending_flag_reg <= pending_flag_next;
         anode_reg        <= anode_next;
         segment_reg      <= segment_next;
         frame_done_reg   <= frame_done_next;
      end
   end

   assign bus.anode     = anode_reg;
   assign bus.segment   = segment_reg;
   assign bus.frameDone = frame_done_reg;

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner
//   Scoreboard bench for seg_display_scanner with SCAN_DIV = 4. The driver
//   pushes the expected display drive for every clock into a queue; a monitor
//   pops and compares on the falling edge (or on an explicit event for the
//   asynchronous reset check).
module tb_seg_display_scanner;
   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic clock = 1'b0;
   logic reset = 1'b0;

   seg_display_scanner_if bus ();

   seg_display_scanner #(.SCAN_DIV(DIV)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      logic [7:0] anode;
      logic [7:0] segment;
      logic       fd;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } wr_t;

   exp_t exp_q[$];
   wr_t  writes[$];
   event chk_ev;

   int   c = 0;
   int   errors = 0;
   int   checks = 0;
   logic bl_g = 1'b0;
   logic h_g  = 1'b0;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Value visible during cycle cyc: the latest write whose frame boundary
   // (last cycle of its frame) lies strictly before cyc.
   function automatic logic [31:0] shown_at(int cyc);
      logic [31:0] s = 32'd0;
      foreach (writes[i]) begin
         int b = writes[i].cyc + (FRAME - 1 - writes[i].cyc % FRAME);
         if (b < cyc) s = writes[i].val;
      end
      return s;
   endfunction

   // Expected drive latched at the edge that ends cycle cyc.
   function automatic exp_t model(int cyc, logic bl, logic h);
      exp_t        e;
      int          d = (cyc / DIV) % 8;
      logic [31:0] s = shown_at(cyc);
      logic [31:0] upper = s >> (4 * d);
      logic [7:0]  p = seg_tab[upper[3:0]];
      if (bl && d >= 1 && upper == 32'd0) p[6:0] = 7'h7F;
      p[7]      = !(d == 0 && h);
      e.cyc     = cyc;
      e.anode   = ~(8'b1 << d);
      e.segment = p;
      e.fd      = (cyc % FRAME == FRAME - 1);
      return e;
   endfunction

   task automatic cycle(input logic vv, input logic [31:0] v);
      exp_t e;
      bus.valueValid   = vv;
      bus.value        = v;
      bus.blankLeading = bl_g;
      bus.halted       = h_g;
      if (vv) writes.push_back('{c, v});
      e = model(c, bl_g, h_g);
      @(posedge clock);
      #1;
      exp_q.push_back(e);
      c++;
      bus.valueValid = 1'b0;
   endtask

   task automatic idle_until(input int target);
      while (c < target) cycle(1'b0, 32'd0);
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         exp_q.push_back('{-1, 8'hFF, 8'hFF, 1'b0});
      end
   endtask

   task automatic release_reset();
      reset = 1'b1;
      c     = 0;
      writes.delete();
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clock or chk_ev);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.anode !== e.anode) begin
               errors++;
               $display("FAIL anode cyc=%0d got=%h exp=%h", e.cyc, bus.anode, e.anode);
            end
            checks++;
            if (bus.segment !== e.segment) begin
               errors++;
               $display("FAIL segment cyc=%0d got=%h exp=%h", e.cyc, bus.segment, e.segment);
            end
            checks++;
            if (bus.frameDone !== e.fd) begin
               errors++;
               $display("FAIL frameDone cyc=%0d got=%b exp=%b", e.cyc, bus.frameDone, e.fd);
            end
         end
      end
   end

   // Driver
   initial begin
      bus.value        = 32'd0;
      bus.valueValid   = 1'b0;
      bus.blankLeading = 1'b0;
      bus.halted       = 1'b0;
      #1;
      reset_cycles(3);
      release_reset();

      // Idle scan: anode stepping and frameDone period.
      idle_until(64);
      // Tear-free update from the middle of digit 3's slot.
      idle_until(78);
      cycle(1'b1, 32'h1234_ABCD);
      idle_until(160);
      $display("tear-free update done at cycle %0d", c);
      // Overwrite within one frame: last write wins.
      idle_until(165);
      cycle(1'b1, 32'h1111_1111);
      idle_until(170);
      cycle(1'b1, 32'h2222_2222);
      idle_until(256);
      $display("overwrite done at cycle %0d", c);
      // Strobe on the digit-7 tick while another value is pending.
      idle_until(270);
      cycle(1'b1, 32'h0000_0005);
      idle_until(287);
      cycle(1'b1, 32'h0000_000F);
      idle_until(352);
      $display("boundary collision done at cycle %0d", c);
      // Leading-zero blanking.
      bl_g = 1'b1;
      cycle(1'b1, 32'h0000_00F0);
      idle_until(448);
      cycle(1'b1, 32'h0000_0000);
      idle_until(512);
      $display("blanking done at cycle %0d", c);
      // Halt indicator on a zero display.
      h_g = 1'b1;
      idle_until(576);
      h_g = 1'b0;
      $display("halt indicator done at cycle %0d", c);
      // Randomized traffic.
      while (c < 1216) begin
         if (c % 16 == 0) bl_g = 1'($urandom_range(0, 1));
         h_g = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0)
            cycle(1'b1, $urandom >> $urandom_range(0, 31));
         else
            cycle(1'b0, 32'd0);
      end
      $display("random traffic done at cycle %0d", c);
      // Asynchronous reset mid-slot with a value pending.
      bl_g = 1'b0;
      h_g  = 1'b0;
      idle_until(1221);
      cycle(1'b1, 32'h0000_9ABC);
      idle_until(1225);
      @(negedge clock);
      #1;
      reset = 1'b0;
      writes.delete();
      exp_q.push_back('{-2, 8'hFF, 8'hFF, 1'b0});
      #1;
      ->chk_ev;
      reset_cycles(2);
      release_reset();
      idle_until(64);
      $display("async reset done at cycle %0d", c);

      @(negedge clock);
      @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending entries exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
